// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per channel a 2-flop synchroniser, a four-state
// stability filter, press/release strobes, and optional long-press hold with auto-repeat.
module debounce_multi #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] held
);

  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES);
  localparam bit HOLD_EN = (HOLD_CYCLES > 0);
  localparam bit REP_EN  = (HOLD_CYCLES > 0) && (REPEAT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [CHANNELS-1:0] w_in;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Polarity is folded in ahead of the synchroniser so its reset value is "inactive".
  assign w_in = ACTIVE_LOW ? ~button : button;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t          r_state;
      state_t          w_state_next;
      logic [SW-1:0]   r_cnt;
      logic [SW-1:0]   w_cnt_next;
      logic [HW-1:0]   r_hold;
      logic [HW-1:0]   w_hold_next;
      logic [RW-1:0]   r_rep;
      logic [RW-1:0]   w_rep_next;
      logic            r_deb;
      logic            r_pressed;
      logic            r_released;
      logic            r_held;
      logic            w_deb_next;
      logic            w_held_next;
      logic            w_repeat;
      logic            w_pressed_next;
      logic            w_released_next;
      logic            w_sample;

      assign w_sample = r_sync2[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_hold     <= '0;
          r_rep      <= '0;
          r_deb      <= 1'b0;
          r_pressed  <= 1'b0;
          r_released <= 1'b0;
          r_held     <= 1'b0;
        end else begin
          r_state    <= w_state_next;
          r_cnt      <= w_cnt_next;
          r_hold     <= w_hold_next;
          r_rep      <= w_rep_next;
          r_deb      <= w_deb_next;
          r_pressed  <= w_pressed_next;
          r_released <= w_released_next;
          r_held     <= w_held_next;
        end
      end

      // The first qualifying sample counts as 1, so a count of DEBOUNCE_CYCLES commits.
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          IDLE: begin
            if (w_sample) begin
              if (DEB_MAX == SW'(1)) begin
                w_state_next = DOWN;
                w_cnt_next   = '0;
              end else begin
                w_state_next = PRESS_WAIT;
                w_cnt_next   = SW'(1);
              end
            end
          end
          PRESS_WAIT: begin
            if (!w_sample) begin
              w_state_next = IDLE;
              w_cnt_next   = '0;
            end else if (r_cnt + SW'(1) == DEB_MAX) begin
              w_state_next = DOWN;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + SW'(1);
            end
          end
          DOWN: begin
            if (!w_sample) begin
              if (DEB_MAX == SW'(1)) begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
              end else begin
                w_state_next = RELEASE_WAIT;
                w_cnt_next   = SW'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (w_sample) begin
              w_state_next = DOWN;
              w_cnt_next   = '0;
            end else if (r_cnt + SW'(1) == DEB_MAX) begin
              w_state_next = IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + SW'(1);
            end
          end
          default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        endcase
      end

      always_comb begin
        w_deb_next  = (w_state_next == DOWN) || (w_state_next == RELEASE_WAIT);
        w_hold_next = '0;
        w_held_next = 1'b0;
        w_rep_next  = '0;
        w_repeat    = 1'b0;
        // Hold count starts on the edge after debounced rises and saturates at HOLD_CYCLES.
        if (HOLD_EN && w_deb_next) begin
          w_hold_next = r_hold;
          if (r_deb && (r_hold != HOLD_MAX)) begin
            w_hold_next = r_hold + HW'(1);
          end
          w_held_next = (w_hold_next == HOLD_MAX);
        end
        if (REP_EN && w_held_next) begin
          if (!r_held) begin
            w_repeat = 1'b1;
          end else if (r_rep + RW'(1) == REP_MAX) begin
            w_repeat = 1'b1;
          end else begin
            w_rep_next = r_rep + RW'(1);
          end
        end
        w_pressed_next  = (!r_deb && w_deb_next) || w_repeat;
        w_released_next = r_deb && !w_deb_next;
      end

      assign debounced[gi] = r_deb;
      assign pressed[gi]   = r_pressed;
      assign released[gi]  = r_released;
      assign held[gi]      = r_held;
    end
  endgenerate

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button debouncer: each of `CHANNELS` raw inputs is synchronised, filtered by a per-channel stability counter, and presented as a clean level plus single-cycle press and release strobes. Optional long-press detection and auto-repeat strobes serve menu-style inputs. It sits between the board I/O pins and the control logic of the io subsystem, and supersedes the single-button debouncer.

## Interface
- `CHANNELS`, 4: number of independent button inputs, ≥1.
- `DEBOUNCE_CYCLES`, 500: consecutive stable synchronised samples required to change state (10 µs at 50 MHz), ≥1.
- `HOLD_CYCLES`, 25_000_000: cycles `debounced` must stay high before `held` asserts; 0 disables hold and repeat.
- `REPEAT_CYCLES`, 5_000_000: auto-repeat period for `pressed` while `held`; 0 disables repeat.
- `ACTIVE_LOW`, 0: 1 means an inactive input reads 1; the input is inverted before filtering.
- `clk` in 1: single clock; all logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `button` in CHANNELS: raw asynchronous inputs, one bit per channel.
- `debounced` out CHANNELS: filtered level, 1 = pressed.
- `pressed` out CHANNELS: one-cycle strobe on a debounced rise and on each auto-repeat.
- `released` out CHANNELS: one-cycle strobe on a debounced fall.
- `held` out CHANNELS: level, high while the long-press condition holds.

## Operation
- **Polarity:** when `ACTIVE_LOW`=1, `button` is inverted at the input; everything downstream is active-high.
- **Synchroniser:** 2-flop synchroniser per channel. Both flops reset to the inactive level (0 after polarity).
- **Per-channel FSM states:**
  - `IDLE`: stable released.
  - `PRESS_WAIT`: synchronised input high, counting.
  - `DOWN`: stable pressed.
  - `RELEASE_WAIT`: synchronised input low, counting.
- **Transitions:**
  - `IDLE`→`PRESS_WAIT` when the synchronised sample is 1; the counter loads 1.
  - `PRESS_WAIT`: a sample of 1 increments the counter. When the count reaches `DEBOUNCE_CYCLES`, go to `DOWN`. A sample of 0 returns to `IDLE` and clears the counter.
  - `DOWN`/`RELEASE_WAIT` behave symmetrically with inverted sample polarity.
- **Counter widths:**
  - Stability counter: `$clog2(DEBOUNCE_CYCLES+1)`.
  - Hold counter: `$clog2(HOLD_CYCLES+1)`.
  - Repeat counter: `$clog2(REPEAT_CYCLES+1)`.
  - No counter ever wraps: the stability counter is cleared on every state change, and the hold counter saturates.
- **Outputs:**
  - `debounced` is 1 in `DOWN` and `RELEASE_WAIT`.
  - `pressed` fires on the `IDLE`→`DOWN` path edge, and on each repeat.
  - `released` fires on the edge entering `IDLE` from `RELEASE_WAIT`.
- **Hold counter:** runs while `debounced`=1 (including during `RELEASE_WAIT`) and clears when `debounced` falls.
- **Held:** `held` rises on the edge where the hold counter reaches `HOLD_CYCLES`. It stays high until the edge on which `debounced` falls, and clears on that same edge.
- **Auto-repeat:** active when `REPEAT_CYCLES`>0 and `held`=1.
  - A `pressed` strobe is issued on the edge `held` rises.
  - A further strobe follows every `REPEAT_CYCLES` edges thereafter.
  - No repeat strobe is issued on the release edge.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- **Reset:** assertion of `rst_n` at any time, including mid-count, immediately forces:
  - all FSMs to `IDLE`;
  - all counters to 0;
  - all outputs to 0.

## Timing
- **Reset values:** `debounced`, `pressed`, `released`, `held` = 0.
- **Press latency:**
  - Take the first edge sampling an active input as edge 1, with the input held stable.
  - `debounced` rises and `pressed` pulses on edge 2+`DEBOUNCE_CYCLES`.
- **Release latency:** symmetric; `released` pulses on the edge `debounced` falls.
- **Glitch rejection:** any excursion of ≤`DEBOUNCE_CYCLES`−1 synchronised samples produces no output change. The next excursion restarts counting from 1.
- **Strobe width:** `pressed` and `released` are high for exactly one cycle. They are never both high on the same channel in the same cycle.
- **Hold:** `held` rises exactly `HOLD_CYCLES` edges after the `debounced` rise edge.

## Test plan
Bench parameters: `CHANNELS`=2, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=3, `ACTIVE_LOW`=0 unless stated.

1. **Reset:** assert `rst_n`=0 with `button`=2'b11 → all outputs 0. Release reset and keep ch0 high → `debounced[0]` rises on edge 6, and `pressed[0]` pulses for 1 cycle on edge 6.
2. **Glitch:**
   - Ch0 high for 3 cycles then low → no output change.
   - Bounce pattern 1,1,0,1,1,1,1 → `debounced[0]` rises 4 synchronised samples after the last 0.
3. **Hold and repeat:**
   - Keep ch0 pressed → `held[0]` rises 10 edges after the `debounced` rise, with `pressed[0]` strobes at that edge, +3 and +6.
   - Release → `released[0]` pulses; `held[0]` and `debounced[0]` fall on the same edge, with no repeat strobe.
4. **Simultaneous channels:**
   - Ch0 and ch1 pressed on the same edge → identical simultaneous strobes.
   - Ch1 bouncing does not disturb ch0 timing.
5. **Polarity:** `ACTIVE_LOW`=1 with `button` idle at 2'b11 → all outputs 0. Ch0 driven 0 → `debounced[0]`=1 after 2+4 edges.
6. **Reset mid-operation:** assert `rst_n` mid-`PRESS_WAIT` and again while `held`=1 → outputs clear immediately. After reset release, a fresh full 2+4 latency is required.
